// File: rtl/j_cntdn4.sv
// j_cntdn4: four-bit loadable down-counter with a one-cycle terminal-count
// strobe and a sticky expiry flag for the Jerry interrupt/timer logic.
//
// Build option: define JCNTDN_AUTORELOAD_EN to reload the count from the last
// loaded value on an enabled edge at zero (periodic mode). Without it the
// counter parks at zero (one-shot mode).
//
// All outputs come straight from flops; there is no combinational path from
// any input to any output.

module j_cntdn4 (
  input  logic clk,
  input  logic reset_n,
  input  logic sys_clk,
  input  logic ldval_0,
  input  logic ldval_1,
  input  logic ldval_2,
  input  logic ldval_3,
  input  logic ld,
  input  logic cnten,
  input  logic ack,
  output logic count_0,
  output logic count_1,
  output logic count_2,
  output logic count_3,
  output logic tc,
  output logic expired
);

  // The simulation clock is carried for the shared flop primitives only; the
  // behavioural flops here run purely on clk.
  logic unused_sys_clk;
  assign unused_sys_clk = sys_clk;

  logic [3:0] ldval;
  assign ldval = {ldval_3, ldval_2, ldval_1, ldval_0};

  logic [3:0] count_q, count_d;
  logic [3:0] reload_q, reload_d;
  logic       tc_q, tc_d;
  logic       expired_q, expired_d;

`ifndef JCNTDN_AUTORELOAD_EN
  // In one-shot builds the reload value is stored but never consumed.
  logic unused_reload;
  assign unused_reload = ^reload_q;
`endif

  // Next-state for count, reload and the terminal-count strobe; ld beats cnten.
  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (ld) begin
      count_d  = ldval;
      reload_d = ldval;
    end else if (cnten) begin
      if (count_q != 4'd0) begin
        count_d = count_q - 4'd1;
        // Strobe only on the 1 -> 0 step, so a parked zero never re-fires.
        tc_d    = (count_q == 4'd1);
      end else begin
`ifdef JCNTDN_AUTORELOAD_EN
        count_d = reload_q;
`else
        count_d = 4'd0;
`endif
      end
    end
  end

  // Sticky expiry: a new terminal count wins over a simultaneous ack.
  always_comb begin
    expired_d = expired_q;
    if (tc_d) begin
      expired_d = 1'b1;
    end else if (ack) begin
      expired_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q   <= 4'd0;
      reload_q  <= 4'd0;
      tc_q      <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      reload_q  <= reload_d;
      tc_q      <= tc_d;
      expired_q <= expired_d;
    end
  end

  assign count_0 = count_q[0];
  assign count_1 = count_q[1];
  assign count_2 = count_q[2];
  assign count_3 = count_q[3];
  assign tc      = tc_q;
  assign expired = expired_q;

endmodule
